// File: rtl/div_z38_by_b18_seq_verilator.sv
// Sequential restoring divider: z (38b) / b (18b) -> 20-bit quotient and 18-bit remainder.
// Recovers the A operand of a DSP38 unsigned 20x18 product; overflow is flagged up front.
module div_z38_by_b18_seq_verilator (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] z,
    input  logic [17:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [19:0] a_out,
    output logic [17:0] rem_out,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic [17:0] r_rem;
    logic [17:0] r_b;
    logic [19:0] r_q;
    logic        r_ovf;

    logic        w_ovf_in;
    logic        w_last;
    logic        w_ge;
    logic [18:0] w_t;
    logic [17:0] w_rem_nxt;

    // Quotient fits in 20 bits only when the upper dividend half is below b; b == 0 always trips this.
    assign w_ovf_in = (z[37:20] >= b);
    assign w_last   = (r_cnt == 5'd19);

    assign w_t       = {r_rem, r_q[19]};
    assign w_ge      = (w_t >= {1'b0, r_b});
    // rem < b keeps t - b below 2^18, so the low 18 bits of the difference are exact.
    assign w_rem_nxt = w_ge ? (w_t[17:0] - r_b) : w_t[17:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = w_ovf_in ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_b   <= b;
                        r_cnt <= '0;
                        if (w_ovf_in) begin
                            r_ovf <= 1'b1;
                            r_q   <= '1;
                            r_rem <= '0;
                        end else begin
                            r_ovf <= 1'b0;
                            r_rem <= z[37:20];
                            r_q   <= z[19:0];
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[18:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign a_out   = r_q;
    assign rem_out = r_rem;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_div_z38_by_b18_seq_verilator.sv
// Self-checking bench for div_z38_by_b18_seq_verilator against a plain-arithmetic division model.
module tb_div_z38_by_b18_seq_verilator;

    logic        clk;
    logic        reset;
    logic [37:0] z;
    logic [17:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] a_out;
    logic [17:0] rem_out;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    div_z38_by_b18_seq_verilator dut (
        .clk       (clk),
        .reset     (reset),
        .z         (z),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_out     (a_out),
        .rem_out   (rem_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [37:0] zz, input logic [17:0] bb,
                                    output logic [19:0] ea, output logic [17:0] er, output logic eo);
        logic [63:0] zl;
        logic [63:0] bl;
        logic [63:0] q;
        logic [63:0] r;
        zl = {26'b0, zz};
        bl = {46'b0, bb};
        if (bb == 18'd0) begin
            ea = 20'hFFFFF; er = 18'd0; eo = 1'b1;
        end else begin
            q = zl / bl;
            r = zl % bl;
            if (q > 64'hFFFFF) begin
                ea = 20'hFFFFF; er = 18'd0; eo = 1'b1;
            end else begin
                ea = q[19:0]; er = r[17:0]; eo = 1'b0;
            end
        end
    endfunction

    function automatic logic [37:0] rand_z();
        logic [5:0]  hi;
        logic [31:0] lo;
        hi = 6'($urandom_range(0, 63));
        lo = $urandom();
        return {hi, lo};
    endfunction

    // Drives one operation, scrambles z/b after accept, waits (bounded) for the result, then handshakes.
    task automatic run_op(input logic [37:0] oz, input logic [17:0] ob,
                          output logic [19:0] oa, output logic [17:0] orem, output logic oovf,
                          output int lat, output logic rdy_seen);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        rdy_seen = in_ready;
        z = oz; b = ob; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        z = rand_z(); b = 18'($urandom());
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        oa = a_out; orem = rem_out; oovf = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (a_out !== 20'd0) begin errors++; $display("FAIL reset_a_out: got %0h expected 0", a_out); end
        checks++; if (rem_out !== 18'd0) begin errors++; $display("FAIL reset_rem_out: got %0h expected 0", rem_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [37:0] tz [4];
        logic [17:0] tb [4];
        int          tl [4];
        logic [19:0] oa, ea;
        logic [17:0] orr, er;
        logic        oo, eo, rdy;
        int          lat;
        tz[0] = 38'd1000;                    tb[0] = 18'd7;       tl[0] = 21;
        tz[1] = 38'(64'hFFFFF * 64'h3FFFF);  tb[1] = 18'h3FFFF;   tl[1] = 21;
        tz[2] = 38'd5;                       tb[2] = 18'd0;       tl[2] = 1;
        tz[3] = 38'h4_0000_0000;             tb[3] = 18'd4;       tl[3] = 1;
        for (int i = 0; i < 4; i++) begin
            run_op(tz[i], tb[i], oa, orr, oo, lat, rdy);
            ref_div(tz[i], tb[i], ea, er, eo);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, rdy); end
            checks++; if (lat != tl[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tl[i]); end
            checks++; if (oa !== ea) begin errors++; $display("FAIL dir%0d_a_out: got %0h expected %0h", i, oa, ea); end
            checks++; if (orr !== er) begin errors++; $display("FAIL dir%0d_rem_out: got %0h expected %0h", i, orr, er); end
            checks++; if (oo !== eo) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", i, oo, eo); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_ready_after_hs: got %b expected 1", i, in_ready); end
        end
        checks++; if (ea !== 20'hFFFFF || er !== 18'd0 || eo !== 1'b1) begin errors++; $display("FAIL dir_model_ovf: got %0h/%0h/%b expected fffff/0/1", ea, er, eo); end
    endtask

    task automatic test_hold();
        logic [19:0] ea;
        logic [17:0] er;
        logic        eo;
        int          lat;
        ref_div(38'd12345678, 18'd1234, ea, er, eo);
        z = 38'd12345678; b = 18'd1234; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 21) begin errors++; $display("FAIL hold_latency: got %0d expected 21", lat); end
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            z = rand_z(); b = 18'($urandom());
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_flags%0d: got v=%b r=%b expected v=1 r=0", i, out_valid, in_ready); end
            checks++; if (a_out !== ea || rem_out !== er || ovf !== eo) begin errors++; $display("FAIL hold_data%0d: got %0h/%0h/%b expected %0h/%0h/%b", i, a_out, rem_out, ovf, ea, er, eo); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got r=%b v=%b expected r=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_reset_abort();
        logic [19:0] oa;
        logic [17:0] orr;
        logic        oo, rdy;
        int          lat;
        z = 38'd1000; b = 18'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_calc_flags: got r=%b v=%b expected r=1 v=0", in_ready, out_valid); end
        checks++; if (a_out !== 20'd0 || rem_out !== 18'd0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_calc_regs: got %0h/%0h/%b expected 0/0/0", a_out, rem_out, ovf); end
        out_ready = 1'b0;
        repeat (25) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b expected 0", out_valid); end
        run_op(38'd99, 18'd10, oa, orr, oo, lat, rdy);
        checks++; if (oa !== 20'd9 || orr !== 18'd9 || oo !== 1'b0 || lat != 21) begin errors++; $display("FAIL abort_next_op: got %0d/%0d/%b lat %0d expected 9/9/0 lat 21", oa, orr, oo, lat); end
        // Reset while a result waits in DONE, with out_ready asserted in the same cycle.
        z = 38'd5; b = 18'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_done_setup: got %b expected 1", out_valid); end
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0 || a_out !== 20'd0) begin errors++; $display("FAIL abort_done: got v=%b r=%b ovf=%b a=%0h expected 0/1/0/0", out_valid, in_ready, ovf, a_out); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] ea1, ea2;
        logic [17:0] er1, er2;
        logic        eo1, eo2;
        int          lat;
        ref_div(38'd777777, 18'd333, ea1, er1, eo1);
        ref_div(38'd123456789, 18'd4321, ea2, er2, eo2);
        out_ready = 1'b1;
        z = 38'd777777; b = 18'd333; in_valid = 1'b1;
        @(posedge clk); #1;
        z = 38'd123456789; b = 18'd4321;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 21 || a_out !== ea1 || rem_out !== er1 || ovf !== eo1) begin errors++; $display("FAIL b2b_first: got %0h/%0h/%b lat %0d expected %0h/%0h/%b lat 21", a_out, rem_out, ovf, lat, ea1, er1, eo1); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_on_hs: got r=%b v=%b expected r=1 v=0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b expected 0", in_ready); end
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 21 || a_out !== ea2 || rem_out !== er2 || ovf !== eo2) begin errors++; $display("FAIL b2b_second: got %0h/%0h/%b lat %0d expected %0h/%0h/%b lat 21", a_out, rem_out, ovf, lat, ea2, er2, eo2); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [19:0] ra, oa, ea;
        logic [17:0] rb, orr, er;
        logic [37:0] rz;
        logic        oo, eo, rdy, prod;
        logic [63:0] recon;
        int          lat, elat;
        for (int n = 0; n < 2000; n++) begin
            prod = ($urandom_range(0, 3) != 0);
            ra = 20'($urandom());
            case ($urandom_range(0, 3))
                0:       rb = 18'($urandom_range(1, 15));
                1:       rb = 18'h3FFFF - 18'($urandom_range(0, 15));
                default: rb = 18'($urandom());
            endcase
            if (prod) begin
                if (rb == 18'd0) rb = 18'd1;
                rz = 38'({44'b0, ra} * {46'b0, rb});
            end else begin
                rz = rand_z();
                if ($urandom_range(0, 9) == 0) rb = 18'd0;
            end
            ref_div(rz, rb, ea, er, eo);
            elat = eo ? 1 : 21;
            run_op(rz, rb, oa, orr, oo, lat, rdy);
            checks++; if (rdy !== 1'b1 || lat != elat) begin errors++; $display("FAIL rnd%0d_timing: got rdy=%b lat=%0d expected rdy=1 lat=%0d", n, rdy, lat, elat); end
            checks++; if (oa !== ea || orr !== er || oo !== eo) begin errors++; $display("FAIL rnd%0d_result: z=%0h b=%0h got %0h/%0h/%b expected %0h/%0h/%b", n, rz, rb, oa, orr, oo, ea, er, eo); end
            if (prod) begin
                checks++; if (oa !== ra || orr !== 18'd0 || oo !== 1'b0) begin errors++; $display("FAIL rnd%0d_recover_a: got %0h/%0h/%b expected %0h/0/0", n, oa, orr, oo, ra); end
            end
            if (!eo) begin
                recon = {44'b0, oa} * {46'b0, rb} + {46'b0, orr};
                checks++; if (recon !== {26'b0, rz} || !(orr < rb)) begin errors++; $display("FAIL rnd%0d_identity: got a*b+r=%0h rem=%0h expected %0h rem<%0h", n, recon, orr, rz, rb); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
